// File: rtl/uart_rx_stream_pkg.sv
// uart_rx_pkg: shared types and constants for the uart_rx_stream receiver.
// Optional build macro: UART_RX_PARITY_EN (8E1 framing when defined).
package uart_rx_pkg;

   localparam int DATA_BITS            = 8;
   localparam int CLKS_PER_BIT_DEFAULT = 4167;   // 40 MHz / 9600 baud

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } rx_state_e;

   // Even-parity bit for a data byte: 1 when the byte holds an odd number of ones.
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Byte stream from the UART receiver to the user logic (valid/ready plus occupancy).
interface uart_rx_stream_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]       m_tdata;
   logic             m_tvalid;
   logic             m_tready;
   logic [LVL_W-1:0] fifo_level;

   modport master (output m_tdata, output m_tvalid, output fifo_level, input m_tready);
   modport slave  (input m_tdata, input m_tvalid, input fifo_level, output m_tready);
endinterface

// File: rtl/uart_rx_stream_sync_fifo.sv
// uart_rx_sync_fifo: first-word fall-through byte FIFO for received bytes.
// A push into a full FIFO is dropped (and flagged) unless a pop frees a slot the same cycle.
module uart_rx_sync_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push_i,
   input  logic [7:0]                    data_i,
   input  logic                          pop_i,
   output logic [7:0]                    data_o,
   output logic                          empty_o,
   output logic                          overrun_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        overrun_q, overrun_d;
   logic        full_s, push_ok_s, pop_ok_s;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok_s  = pop_i && !empty_o;
   assign push_ok_s = push_i && (!full_s || pop_ok_s);
   assign level_o   = wr_ptr_q - rd_ptr_q;
   assign data_o    = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
   assign overrun_o = overrun_q;

   // Next pointer values and the single-cycle overrun flag.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      overrun_d = 1'b0;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_i && !push_ok_s) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = 1'b0;
      end
   end

   // Pointer and flag registers, cleared by reset (which also empties the FIFO).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= {(AW+1){1'b0}};
         rd_ptr_q  <= {(AW+1){1'b0}};
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage array; contents need no reset because empty masks the head.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: oversampling UART receiver (8N1, LSB first) feeding a byte FIFO
// presented as a valid/ready stream. Framing/overrun errors are one-cycle pulses.
// Optional build macro: UART_RX_PARITY_EN switches framing to 8E1 and drives parity_err_o.
module uart_rx_stream
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              rx_i,
   uart_rx_stream_if.master  m_if,
   output logic              frame_err_o,
   output logic              overrun_o,
   output logic              parity_err_o
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_ZERO      = {BAUD_W{1'b0}};
   localparam logic [BAUD_W-1:0] BAUD_ONE       = BAUD_W'(1);
   localparam logic [BAUD_W-1:0] BAUD_LAST      = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

   logic              rx_meta_q, rxs_q;
   rx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              frame_err_q, frame_err_d;
   logic              push_s, pop_s, fifo_empty_s, par_ok_s;

`ifdef UART_RX_PARITY_EN
   logic par_bad_q, par_bad_d;
   logic parity_err_q, parity_err_d;
   assign par_ok_s     = !par_bad_q;
   assign parity_err_o = parity_err_q;
`else
   assign par_ok_s     = 1'b1;
   assign parity_err_o = 1'b0;
`endif

   assign frame_err_o   = frame_err_q;
   assign m_if.m_tvalid = !fifo_empty_s;
   assign pop_s         = !fifo_empty_s && m_if.m_tready;

   // Two-flop synchroniser for the asynchronous serial line (idle high).
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rxs_q     <= rx_meta_q;
      end
   end

   // Frame FSM: next state, baud/bit counters, shift register, push and error pulses.
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q + BAUD_ONE;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      push_s      = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            baud_d = BAUD_ZERO;
            if (!rxs_q) begin
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (baud_q == BAUD_HALF_LAST) begin
               baud_d    = BAUD_ZERO;
               bit_idx_d = 3'd0;
               if (!rxs_q) begin
                  state_d = DATA;
               end else begin
                  state_d = IDLE;   // glitch shorter than half a bit
               end
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d             = BAUD_ZERO;
               shift_d[bit_idx_q] = rxs_q;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               state_d = DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (baud_q == BAUD_LAST) begin
               baud_d       = BAUD_ZERO;
               par_bad_d    = (rxs_q != even_parity(shift_q));
               parity_err_d = (rxs_q != even_parity(shift_q));
               state_d      = STOP;
            end else begin
               state_d = PARITY;
            end
         end
`endif
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = BAUD_ZERO;
               if (rxs_q) begin
                  push_s  = par_ok_s;
                  state_d = IDLE;
               end else begin
                  frame_err_d = par_ok_s;
                  state_d     = WAIT_IDLE;
               end
            end else begin
               state_d = STOP;
            end
         end
         WAIT_IDLE: begin
            baud_d = BAUD_ZERO;
            if (rxs_q) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = BAUD_ZERO;
         end
      endcase
   end

   // FSM and datapath registers; reset abandons any partial frame.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         baud_q      <= BAUD_ZERO;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity verdict for the current frame and its error pulse.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
      end
   end
`endif

   uart_rx_sync_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .push_i    (push_s),
      .data_i    (shift_q),
      .pop_i     (pop_s),
      .data_o    (m_if.m_tdata),
      .empty_o   (fifo_empty_s),
      .overrun_o (overrun_o),
      .level_o   (m_if.fifo_level)
   );

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: table of frames plus directed corner sequences.
module tb_uart_rx_stream;
   localparam int CPB   = 64;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic ferr, ovr, perr;

   always #5 clk = ~clk;

   uart_rx_stream_if #(.FIFO_DEPTH(DEPTH)) s_if ();

   uart_rx_stream #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .rx_i         (rx),
      .m_if         (s_if.master),
      .frame_err_o  (ferr),
      .overrun_o    (ovr),
      .parity_err_o (perr)
   );

   int checks = 0;
   int errors = 0;

   // Monitor state, written only by the monitor process.
   logic [7:0] popped[$];
   int n_valid = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;

   // Sample the DUT on the falling edge: record handshakes and error pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (s_if.m_tvalid && s_if.m_tready) popped.push_back(s_if.m_tdata);
         n_valid <= n_valid + int'(s_if.m_tvalid);
         n_ferr  <= n_ferr + int'(ferr);
         n_ovr   <= n_ovr + int'(ovr);
         n_perr  <= n_perr + int'(perr);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par);
`else
      if (par === 1'bx) $display("parity argument unused");
`endif
      drive_bit(stop);
      rx = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_push;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int b_pop, b_val, b_fe, b_ov, b_pe;

      vecs[0] = '{data: 8'h3D, stop: 1'b1, exp_push: 1, exp_ferr: 0};
      vecs[1] = '{data: 8'h0F, stop: 1'b0, exp_push: 0, exp_ferr: 1};
      vecs[2] = '{data: 8'hA5, stop: 1'b1, exp_push: 1, exp_ferr: 0};
      vecs[3] = '{data: 8'h00, stop: 1'b1, exp_push: 1, exp_ferr: 0};
      vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_push: 1, exp_ferr: 0};
      vecs[5] = '{data: 8'h80, stop: 1'b1, exp_push: 1, exp_ferr: 0};

      rst = 1'b1;
      rx = 1'b1;
      s_if.m_tready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("reset_tvalid", int'(s_if.m_tvalid), 0);
      check("reset_level", int'(s_if.fifo_level), 0);
      check("reset_tdata", int'(s_if.m_tdata), 8'h00);
      check("reset_pulses", int'({ferr, ovr, perr}), 0);
      rst = 1'b0;
      idle_bits(1);

      // Short low glitch while idle: rejected at the half-bit check.
      b_pop = popped.size(); b_fe = n_ferr;
      rx = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rx = 1'b1;
      idle_bits(2);
      check("glitch_no_push", popped.size() - b_pop, 0);
      check("glitch_no_ferr", n_ferr - b_fe, 0);
      check("glitch_level", int'(s_if.fifo_level), 0);

      // Table of frames with the consumer always ready.
      for (int v = 0; v < 6; v++) begin
         b_pop = popped.size(); b_val = n_valid; b_fe = n_ferr; b_ov = n_ovr; b_pe = n_perr;
         send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop);
         idle_bits(3);
         check($sformatf("vec%0d_pushes", v), popped.size() - b_pop, vecs[v].exp_push);
         check($sformatf("vec%0d_valid_cycles", v), n_valid - b_val, vecs[v].exp_push);
         check($sformatf("vec%0d_frame_err", v), n_ferr - b_fe, vecs[v].exp_ferr);
         check($sformatf("vec%0d_overrun", v), n_ovr - b_ov, 0);
         check($sformatf("vec%0d_parity_err", v), n_perr - b_pe, 0);
         check($sformatf("vec%0d_level", v), int'(s_if.fifo_level), 0);
         if (vecs[v].exp_push == 1 && popped.size() > b_pop)
            check($sformatf("vec%0d_data", v), int'(popped[b_pop]), int'(vecs[v].data));
      end

      // Fill the FIFO with the consumer stalled, then overflow by one.
      s_if.m_tready = 1'b0;
      b_pop = popped.size(); b_ov = n_ovr;
      for (int i = 1; i <= 8; i++) begin
         send_frame(8'(i), ^(8'(i)), 1'b1);
         idle_bits(1);
      end
      check("fill_level8", int'(s_if.fifo_level), 8);
      check("fill_no_overrun", n_ovr - b_ov, 0);
      send_frame(8'h09, ^(8'h09), 1'b1);
      idle_bits(1);
      check("overrun_once", n_ovr - b_ov, 1);
      check("overrun_level", int'(s_if.fifo_level), 8);
      check("stalled_head", int'(s_if.m_tdata), 8'h01);
      check("stalled_valid", int'(s_if.m_tvalid), 1);
      s_if.m_tready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("drain_count", popped.size() - b_pop, 8);
      for (int i = 0; i < 8; i++)
         if (popped.size() > b_pop + i)
            check($sformatf("drain_byte%0d", i), int'(popped[b_pop + i]), i + 1);
      check("drain_tvalid", int'(s_if.m_tvalid), 0);
      check("drain_level", int'(s_if.fifo_level), 0);

      // Reset during bit 4 of a frame with three bytes queued.
      s_if.m_tready = 1'b0;
      send_frame(8'h11, ^(8'h11), 1'b1); idle_bits(1);
      send_frame(8'h22, ^(8'h22), 1'b1); idle_bits(1);
      send_frame(8'h33, ^(8'h33), 1'b1); idle_bits(1);
      check("queued3_level", int'(s_if.fifo_level), 3);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h3D >> i));
      rx = 1'b1;   // bit 4 of 0x3D
      repeat (CPB / 2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_level", int'(s_if.fifo_level), 0);
      check("midrst_tvalid", int'(s_if.m_tvalid), 0);
      check("midrst_tdata", int'(s_if.m_tdata), 8'h00);
      check("midrst_pulses", int'({ferr, ovr, perr}), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle_bits(2);
      s_if.m_tready = 1'b1;
      b_pop = popped.size(); b_fe = n_ferr;
      send_frame(8'h3D, ^(8'h3D), 1'b1);
      idle_bits(2);
      check("postrst_pushes", popped.size() - b_pop, 1);
      if (popped.size() > b_pop) check("postrst_data", int'(popped[b_pop]), 8'h3D);
      check("postrst_ferr", n_ferr - b_fe, 0);
      check("postrst_level", int'(s_if.fifo_level), 0);

`ifdef UART_RX_PARITY_EN
      // Wrong parity bit discards the byte; correct parity bit is accepted.
      b_pop = popped.size(); b_pe = n_perr; b_fe = n_ferr;
      send_frame(8'h3D, 1'b0, 1'b1);
      idle_bits(2);
      check("par_bad_pulse", n_perr - b_pe, 1);
      check("par_bad_no_push", popped.size() - b_pop, 0);
      check("par_bad_no_ferr", n_ferr - b_fe, 0);
      b_pe = n_perr;
      send_frame(8'h3D, 1'b1, 1'b1);
      idle_bits(2);
      check("par_ok_no_pulse", n_perr - b_pe, 0);
      check("par_ok_push", popped.size() - b_pop, 1);
      if (popped.size() > b_pop) check("par_ok_data", int'(popped[b_pop]), 8'h3D);
`else
      check("parity_tied_low", n_perr, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
